// File: rtl/mem_ctrl_if.sv
// Bus bundle between the pipeline (fetch + memory stages), the byte-wide RAM
// and mem_ctrl. The master side holds the requesters and the RAM; mem_ctrl is
// the slave that serialises word/half/byte accesses onto the RAM byte port.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_clr;
    logic        if_done;
    logic [31:0] if_is;

    logic        mm_req;
    logic        mm_we;
    logic [31:0] mm_a;
    logic [1:0]  mm_sz;
    logic [31:0] mm_wn;
    logic        mm_done;
    logic [31:0] mm_rn;

    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    modport master (
        output if_req, if_pc, if_clr, mm_req, mm_we, mm_a, mm_sz, mm_wn, ram_din,
        input  if_done, if_is, mm_done, mm_rn, ram_a, ram_wr, ram_dout
    );

    modport slave (
        input  if_req, if_pc, if_clr, mm_req, mm_we, mm_a, mm_sz, mm_wn, ram_din,
        output if_done, if_is, mm_done, mm_rn, ram_a, ram_wr, ram_dout
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction fetch and data access onto a
// byte-wide RAM with one-cycle read latency. Data access wins over fetch.
//
// state  | meaning
// IDLE   | no transfer; ram_a parked at 0; accepts mm first, then if
// IF_RD  | 4-byte fetch; cnt 0..4, byte cnt-1 captured when cnt>=1; if_clr aborts
// MM_RD  | 1/2/4-byte load; cnt 0..N, zero-extended result on mm_rn
// MM_WR  | 1/2/4-byte store; one byte written per cycle, cnt 0..N-1
module mem_ctrl (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IF_RD, MM_RD, MM_WR} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [2:0]  len, len_nxt;
    logic [31:0] addr, addr_nxt;
    logic [31:0] wdata, wdata_nxt;
    logic [31:0] rbuf, rbuf_nxt;
    logic        if_done, if_done_nxt;
    logic        mm_done, mm_done_nxt;
    logic [31:0] if_is, if_is_nxt;
    logic [31:0] mm_rn, mm_rn_nxt;
    logic [31:0] rd_word;
    logic [1:0]  byte_sel;
    logic        mm_ok;
    logic        if_ok;

    function automatic logic [2:0] size_len(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Read byte arriving this cycle belongs to the address presented last cycle.
    assign byte_sel = cnt[1:0] - 2'd1;

    // Merge the incoming RAM byte into the partially assembled read word.
    always_comb begin
        rd_word = rbuf;
        rd_word[{byte_sel, 3'b000} +: 8] = bus.ram_din;
    end

    // Next-state, counter and result logic; everything holds while rdy is low.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        len_nxt     = len;
        addr_nxt    = addr;
        wdata_nxt   = wdata;
        rbuf_nxt    = rbuf;
        if_done_nxt = if_done;
        mm_done_nxt = mm_done;
        if_is_nxt   = if_is;
        mm_rn_nxt   = mm_rn;
        mm_ok       = 1'b0;
        if_ok       = 1'b0;
        if (rdy) begin
            if_done_nxt = 1'b0;
            mm_done_nxt = 1'b0;
            case (state)
                IDLE: begin
                    // A requester whose done is showing has not yet dropped req.
                    mm_ok = bus.mm_req && !mm_done;
                    if_ok = bus.if_req && !bus.if_clr && !if_done;
                    if (mm_ok) begin
                        state_nxt = bus.mm_we ? MM_WR : MM_RD;
                        addr_nxt  = bus.mm_a;
                        len_nxt   = size_len(bus.mm_sz);
                        wdata_nxt = bus.mm_wn;
                        cnt_nxt   = 3'd0;
                        rbuf_nxt  = 32'd0;
                    end else if (if_ok) begin
                        state_nxt = IF_RD;
                        addr_nxt  = bus.if_pc;
                        len_nxt   = 3'd4;
                        cnt_nxt   = 3'd0;
                        rbuf_nxt  = 32'd0;
                    end
                end
                IF_RD, MM_RD: begin
                    if (state == IF_RD && bus.if_clr) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 3'd0;
                    end else begin
                        if (cnt != 3'd0) begin
                            rbuf_nxt = rd_word;
                        end
                        if (cnt == len) begin
                            state_nxt = IDLE;
                            cnt_nxt   = 3'd0;
                            if (state == IF_RD) begin
                                if_done_nxt = 1'b1;
                                if_is_nxt   = rd_word;
                            end else begin
                                mm_done_nxt = 1'b1;
                                mm_rn_nxt   = rd_word;
                            end
                        end else begin
                            cnt_nxt = cnt + 3'd1;
                        end
                    end
                end
                MM_WR: begin
                    if (cnt == len - 3'd1) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = 3'd0;
                        mm_done_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    // State register; reset drops any in-flight transfer without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            len     <= 3'd0;
            addr    <= 32'd0;
            wdata   <= 32'd0;
            rbuf    <= 32'd0;
            if_done <= 1'b0;
            mm_done <= 1'b0;
            if_is   <= 32'd0;
            mm_rn   <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            len     <= len_nxt;
            addr    <= addr_nxt;
            wdata   <= wdata_nxt;
            rbuf    <= rbuf_nxt;
            if_done <= if_done_nxt;
            mm_done <= mm_done_nxt;
            if_is   <= if_is_nxt;
            mm_rn   <= mm_rn_nxt;
        end
    end

    // RAM port: address parked at 0 when idle or in reset, write gated by rdy.
    assign bus.ram_a    = (rst || state == IDLE) ? 32'd0 : addr + {29'd0, cnt};
    assign bus.ram_wr   = !rst && rdy && (state == MM_WR);
    assign bus.ram_dout = wdata[{cnt[1:0], 3'b000} +: 8];

    assign bus.if_done = if_done;
    assign bus.if_is   = if_is;
    assign bus.mm_done = mm_done;
    assign bus.mm_rn   = mm_rn;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a transaction-level reference model (pending access,
// elapsed cycles, golden byte memory) checked every cycle, directed scenarios
// with literal expectations, then a randomized phase.
module tb_mem_ctrl;
    localparam int K_IF = 0;
    localparam int K_LD = 1;
    localparam int K_ST = 2;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            'h10: return 8'h13;
            'h11: return 8'h05;
            'h12: return 8'h50;
            'h13: return 8'h00;
            'h20: return 8'h93;
            'h21: return 8'h00;
            'h22: return 8'h10;
            'h23: return 8'h00;
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        return 32'($urandom_range(0, 1023));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM attached to the DUT ----------------
    // The RAM sits under the same global enable, so its read port freezes with rdy.
    logic [7:0]  ram_mem [0:1023];
    logic        wr_l, rdy_l;
    logic [31:0] a_l;
    logic [7:0]  dout_l;
    logic [39:0] wq [$];

    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = init_byte(i);
        bus.ram_din = 8'h00;
        forever begin
            @(posedge clk);
            if (wr_l) ram_mem[a_l[9:0]] = dout_l;
            if (rdy_l) bus.ram_din <= ram_mem[a_l[9:0]];
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            wr_l   = bus.ram_wr;
            rdy_l  = rdy;
            a_l    = bus.ram_a;
            dout_l = bus.ram_dout;
            if (bus.ram_wr) wq.push_back({bus.ram_a, bus.ram_dout});
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  mem_ref [0:1023];
    bit          m_busy = 0;
    int          m_kind = 0;
    int          m_n = 0;
    int          m_k = 0;
    logic [31:0] m_addr = 0;
    logic [31:0] m_wdata = 0;
    bit          m_if_done = 0;
    bit          m_mm_done = 0;
    logic [31:0] m_if_is = 0;
    logic [31:0] m_mm_rn = 0;

    initial begin
        bit          pd_if, pd_mm;
        logic [31:0] a, v;
        for (int i = 0; i < 1024; i++) mem_ref[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 0; m_if_done = 0; m_mm_done = 0; m_if_is = 0; m_mm_rn = 0;
            end else if (rdy) begin
                pd_if = m_if_done;
                pd_mm = m_mm_done;
                m_if_done = 0;
                m_mm_done = 0;
                if (!m_busy) begin
                    if (bus.mm_req && !pd_mm) begin
                        m_busy = 1; m_k = 0; m_addr = bus.mm_a; m_wdata = bus.mm_wn;
                        m_kind = bus.mm_we ? K_ST : K_LD;
                        m_n = (bus.mm_sz == 2'b00) ? 1 : (bus.mm_sz == 2'b01) ? 2 : 4;
                    end else if (bus.if_req && !bus.if_clr && !pd_if) begin
                        m_busy = 1; m_k = 0; m_addr = bus.if_pc; m_kind = K_IF; m_n = 4;
                    end
                end else if (m_kind == K_IF && bus.if_clr) begin
                    m_busy = 0;
                end else if (m_kind == K_ST) begin
                    a = m_addr + 32'(m_k);
                    mem_ref[a[9:0]] = m_wdata[8*m_k +: 8];
                    m_k++;
                    if (m_k == m_n) begin
                        m_busy = 0; m_mm_done = 1;
                    end
                end else begin
                    m_k++;
                    if (m_k == m_n + 1) begin
                        v = 32'd0;
                        for (int i = 0; i < m_n; i++) begin
                            a = m_addr + 32'(i);
                            v[8*i +: 8] = mem_ref[a[9:0]];
                        end
                        m_busy = 0;
                        if (m_kind == K_IF) begin
                            m_if_done = 1; m_if_is = v;
                        end else begin
                            m_mm_done = 1; m_mm_rn = v;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        bit exp_wr;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_wr = m_busy && m_kind == K_ST && rdy && !rst;
                check("ram_wr", 32'(bus.ram_wr), 32'(exp_wr));
                if (rst || !m_busy) check("ram_a_idle", bus.ram_a, 32'd0);
                else if (m_k < m_n) check("ram_a", bus.ram_a, m_addr + 32'(m_k));
                if (exp_wr) check("ram_dout", 32'(bus.ram_dout), 32'(m_wdata[8*m_k +: 8]));
                check("if_done", 32'(bus.if_done), 32'(m_if_done));
                check("mm_done", 32'(bus.mm_done), 32'(m_mm_done));
                if (m_if_done) check("if_is", bus.if_is, m_if_is);
                if (m_mm_done) check("mm_rn", bus.mm_rn, m_mm_rn);
            end
        end
    end

    task automatic wait_done(input bit is_mm, input string name, output int edges);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!(is_mm ? bus.mm_done : bus.if_done) && edges < 40);
        check({name, "_seen"}, 32'(is_mm ? bus.mm_done : bus.if_done), 32'd1);
    endtask

    task automatic new_mm();
        bus.mm_req = 1'b1;
        bus.mm_we  = 1'($urandom_range(0, 1));
        bus.mm_a   = rand_addr();
        bus.mm_sz  = 2'($urandom_range(0, 3));
        bus.mm_wn  = $urandom;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  e, base, tot;
        bit  ifd_prev, mmd_prev, ifd_rise, mmd_rise;
        rst = 1'b1; rdy = 1'b1;
        bus.if_req = 0; bus.if_pc = 0; bus.if_clr = 0;
        bus.mm_req = 0; bus.mm_we = 0; bus.mm_a = 0; bus.mm_sz = 0; bus.mm_wn = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; chk_en = 1'b1;
        #1;
        check("rst_if_done", 32'(bus.if_done), 32'd0);
        check("rst_mm_done", 32'(bus.mm_done), 32'd0);
        check("rst_if_is", bus.if_is, 32'd0);
        check("rst_mm_rn", bus.mm_rn, 32'd0);
        check("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
        check("rst_ram_a", bus.ram_a, 32'd0);

        // fetch from 0x10
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_pc = 32'h10;
        wait_done(0, "fetch", e);
        check("fetch_lat", 32'(e - 1), 32'd5);
        check("fetch_is", bus.if_is, 32'h0050_0513);
        check("model_fetch_is", m_if_is, 32'h0050_0513);
        bus.if_req = 0;

        // word store then byte load
        @(posedge clk); #1;
        base = wq.size();
        bus.mm_req = 1; bus.mm_we = 1; bus.mm_a = 32'h100; bus.mm_sz = 2'b10; bus.mm_wn = 32'hDEAD_BEEF;
        wait_done(1, "store", e);
        check("store_lat", 32'(e - 1), 32'd4);
        bus.mm_req = 0; bus.mm_we = 0;
        check("store_nwr", 32'(wq.size() - base), 32'd4);
        if (wq.size() - base == 4) begin
            check("store_w0", 32'(wq[base]),     32'h0001_00EF);
            check("store_w1", 32'(wq[base + 1]), 32'h0001_01BE);
            check("store_w2", 32'(wq[base + 2]), 32'h0001_02AD);
            check("store_w3", 32'(wq[base + 3]), 32'h0001_03DE);
        end
        @(posedge clk); #1;
        bus.mm_req = 1; bus.mm_we = 0; bus.mm_a = 32'h102; bus.mm_sz = 2'b00;
        wait_done(1, "lb", e);
        check("lb_lat", 32'(e - 1), 32'd2);
        check("lb_rn", bus.mm_rn, 32'h0000_00AD);
        check("model_lb_rn", m_mm_rn, 32'h0000_00AD);
        bus.mm_req = 0;

        // contention: mm first, fetch accepted in the mm_done cycle
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_pc = 32'h10;
        bus.mm_req = 1; bus.mm_we = 0; bus.mm_a = 32'h100; bus.mm_sz = 2'b10;
        wait_done(1, "cont_mm", e);
        check("cont_mm_lat", 32'(e - 1), 32'd5);
        check("cont_mm_rn", bus.mm_rn, 32'hDEAD_BEEF);
        check("cont_if_idle", 32'(bus.if_done), 32'd0);
        bus.mm_req = 0;
        wait_done(0, "cont_if", e);
        check("cont_if_lat", 32'(e - 1), 32'd5);
        check("cont_if_is", bus.if_is, 32'h0050_0513);
        bus.if_req = 0;

        // flush at cnt=2, then a fresh fetch at 0x20
        @(posedge clk); #1;
        base = wq.size();
        bus.if_req = 1; bus.if_pc = 32'h10;
        repeat (3) @(posedge clk);
        #1 bus.if_clr = 1; bus.if_pc = 32'h20;
        @(posedge clk); #1;
        bus.if_clr = 0;
        #1;
        check("flush_ram_a", bus.ram_a, 32'd0);
        check("flush_no_done", 32'(bus.if_done), 32'd0);
        wait_done(0, "refetch", e);
        check("refetch_lat", 32'(e - 1), 32'd5);
        check("refetch_is", bus.if_is, 32'h0010_0093);
        check("flush_no_wr", 32'(wq.size() - base), 32'd0);
        bus.if_req = 0;

        // stall three cycles during a word read at cnt=1
        @(posedge clk); #1;
        bus.mm_req = 1; bus.mm_we = 0; bus.mm_a = 32'h100; bus.mm_sz = 2'b10;
        repeat (2) @(posedge clk);
        #1 rdy = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ram_a", bus.ram_a, 32'h101);
            @(posedge clk); #1;
        end
        rdy = 1;
        wait_done(1, "stall", e);
        tot = 5 + e - 1;
        check("stall_lat", 32'(tot), 32'd8);
        check("stall_rn", bus.mm_rn, 32'hDEAD_BEEF);
        bus.mm_req = 0;

        // reset in the middle of a word store
        @(posedge clk); #1;
        base = wq.size();
        bus.mm_req = 1; bus.mm_we = 1; bus.mm_a = 32'h200; bus.mm_sz = 2'b10; bus.mm_wn = 32'h1122_3344;
        repeat (2) @(posedge clk);
        #1 rst = 1; bus.mm_req = 0;
        #1;
        check("rstw_ram_wr", 32'(bus.ram_wr), 32'd0);
        check("rstw_ram_a", bus.ram_a, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        #1;
        check("rstw_ram_wr_after", 32'(bus.ram_wr), 32'd0);
        check("rstw_ram_a_after", bus.ram_a, 32'd0);
        check("rstw_mm_rn", bus.mm_rn, 32'd0);
        check("rstw_if_is", bus.if_is, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("rstw_no_done", 32'(bus.mm_done), 32'd0);
            @(posedge clk); #1;
        end
        check("rstw_nwr", 32'(wq.size() - base), 32'd1);
        if (wq.size() - base >= 1) check("rstw_w0", 32'(wq[base]), 32'h0002_0044);

        // randomized traffic
        ifd_prev = 0; mmd_prev = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            ifd_rise = bus.if_done && !ifd_prev; ifd_prev = bus.if_done;
            mmd_rise = bus.mm_done && !mmd_prev; mmd_prev = bus.mm_done;
            rst = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            if (rst) begin
                bus.mm_req = 0; bus.if_req = 0; bus.if_clr = 0;
            end else begin
                if (bus.mm_req && mmd_rise) begin
                    if ($urandom_range(0, 1) == 1) new_mm(); else bus.mm_req = 0;
                end else if (!bus.mm_req && $urandom_range(0, 3) == 0) begin
                    new_mm();
                end else if (bus.mm_req && $urandom_range(0, 7) == 0) begin
                    bus.mm_a = rand_addr(); bus.mm_wn = $urandom;
                end
                if (bus.if_req && ifd_rise) begin
                    if ($urandom_range(0, 1) == 1) bus.if_pc = rand_addr(); else bus.if_req = 0;
                end else if (!bus.if_req && $urandom_range(0, 3) == 0) begin
                    bus.if_req = 1; bus.if_pc = rand_addr();
                end
                bus.if_clr = ($urandom_range(0, 11) == 0);
                if (bus.if_clr && bus.if_req) bus.if_pc = rand_addr();
            end
        end

        @(posedge clk); #1;
        rst = 0; rdy = 1; bus.mm_req = 0; bus.if_req = 0; bus.if_clr = 0;
        repeat (20) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
